// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial 4-bit subtractor: {Bout, D} = A - B - Bin, one bit per clock, LSB first.
// Operands are latched on the accepting edge; results update only on the done edge.
module four_bit_serial_subtractor (
   input  logic clk,
   input  logic rst,
   input  logic A0,
   input  logic A1,
   input  logic A2,
   input  logic A3,
   input  logic B0,
   input  logic B1,
   input  logic B2,
   input  logic B3,
   input  logic Bin,
   input  logic start,
   output logic busy,
   output logic done,
   output logic D0,
   output logic D1,
   output logic D2,
   output logic D3,
   output logic Bout,
   output logic V
);

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-2:0]    sr;
   logic [CW-1:0]   cnt;
   logic            br;

   logic            a_bit_c;
   logic            b_bit_c;
   logic            d_bit_c;
   logic            br_next_c;

   // Single full-subtractor step on the bit selected by the counter
   always_comb begin
      a_bit_c   = a_q[cnt];
      b_bit_c   = b_q[cnt];
      d_bit_c   = a_bit_c ^ b_bit_c ^ br;
      br_next_c = (~a_bit_c & b_bit_c) | (~(a_bit_c ^ b_bit_c) & br);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         a_q   <= '0;
         b_q   <= '0;
         sr    <= '0;
         cnt   <= '0;
         br    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         D0    <= 1'b0;
         D1    <= 1'b0;
         D2    <= 1'b0;
         D3    <= 1'b0;
         Bout  <= 1'b0;
         V     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_q   <= {A3, A2, A1, A0};
                  b_q   <= {B3, B2, B1, B0};
                  br    <= Bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_SHIFT;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               // Low difference bits collect MSB-first so sr ends as {d2,d1,d0}
               sr  <= {d_bit_c, sr[W-2:1]};
               br  <= br_next_c;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) begin
                  D0    <= sr[0];
                  D1    <= sr[1];
                  D2    <= sr[2];
                  D3    <= d_bit_c;
                  Bout  <= br_next_c;
                  V     <= (a_q[W-1] ^ b_q[W-1]) & (a_q[W-1] ^ d_bit_c);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
